washing_controller: RTL and testbench
=====================================

WASHING_CONTROLLER -- requirements
Module: washing_controller

Interface
REQ-001 SHALL have parameter FILL_TIMEOUT, default 8, meaning the maximum number of FILL cycles allowed without sig_Full.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: user start request.
REQ-005 SHALL have port cancel, input, 1 bit: user cancel, honoured in READY only.
REQ-006 SHALL have port door_closed, input, 1 bit: 1 = door shut.
REQ-007 SHALL have port clear_error, input, 1 bit: user acknowledge of ERROR.
REQ-008 SHALL have inputs sig_Full, sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed, sig_Drain_Completed and sig_Delay, 1 bit each: phase-done flags from the downstream timer.
REQ-009 SHALL have port state, output, 9 bits: one-hot phase state driven to the timer.
REQ-010 SHALL have outputs water_valve, motor_on, motor_fast, drain_pump, door_lock, done_led and error_flag, 1 bit each: actuator and indicator drives.
REQ-011 SHALL have port cycles_done, output, 8 bits: count of completed wash cycles.

Function
REQ-012 SHALL encode state one-hot as IDLE=9'h001, READY=9'h002, FILL=9'h004, WASH=9'h008, RINSE=9'h010, SPIN=9'h020, DRAIN=9'h040, COMPLETE=9'h080, ERROR=9'h100.
REQ-013 SHALL register state; all transitions SHALL take effect on the rising clk edge after the qualifying input is sampled (1-cycle latency).
REQ-014 IDLE -> READY SHALL occur when start=1 and door_closed=1; start with the door open SHALL be ignored.
REQ-015 In READY: cancel=1 SHALL return to IDLE; otherwise sig_Delay=1 SHALL go to FILL; if both are high in the same cycle, cancel SHALL win.
REQ-016 Phase transitions SHALL be: FILL -> WASH on sig_Full; WASH -> RINSE on sig_Wash_Completed; RINSE -> SPIN on sig_Rinse_Completed; SPIN -> DRAIN on sig_Spin_Completed; DRAIN -> COMPLETE on sig_Drain_Completed.
REQ-017 In READY..DRAIN, door_closed=0 SHALL go to ERROR, with priority over every other transition in the same cycle.
REQ-018 COMPLETE -> IDLE SHALL occur when door_closed=0, i.e. on door open.
REQ-019 ERROR -> IDLE SHALL occur only when clear_error=1 and door_closed=1; the FSM SHALL otherwise stay in ERROR.
REQ-020 Outputs SHALL be Moore, decoded from registered state:
- water_valve = FILL
- motor_on = WASH|RINSE|SPIN
- motor_fast = SPIN
- drain_pump = DRAIN|ERROR
- door_lock = FILL..DRAIN
- done_led = COMPLETE
- error_flag = ERROR
REQ-021 cycles_done SHALL increment by 1 on each DRAIN -> COMPLETE transition and saturate at 8'hFF, with no wrap.
REQ-022 Any non-one-hot state value SHALL recover to ERROR on the next edge.
REQ-023 Every cycle run SHALL pass through IDLE so that the timer clears its counters.

Reset
REQ-024 With rst_n=0 at a clk edge, the block SHALL set state=IDLE, cycles_done=0, the fill watchdog to 0, and all actuator/indicator outputs to 0.
REQ-025 Reset SHALL override all inputs and SHALL take effect from any state, including mid-phase.

Configuration
REQ-026 Macro FILL_WATCHDOG_EN SHALL control the fill watchdog.
REQ-027 When FILL_WATCHDOG_EN is defined:
- an 8-bit counter SHALL clear on entry to FILL and increment each cycle in FILL;
- if it reaches FILL_TIMEOUT with sig_Full=0, the FSM SHALL go to ERROR;
- sig_Full=1 in that same cycle SHALL win, going to WASH.
REQ-028 When FILL_WATCHDOG_EN is undefined, there SHALL be no counter, and FILL SHALL leave only via sig_Full or door open.

Verification
REQ-029 Bench SHALL cover normal run: reset, door_closed=1, start pulse, then each timer flag pulsed once -> state walks IDLE..COMPLETE one-hot, cycles_done 0->1, done_led=1; door open -> IDLE.
REQ-030 Bench SHALL cover cancel race: in READY drive cancel=1 and sig_Delay=1 together -> next state IDLE, water_valve stays 0.
REQ-031 Bench SHALL cover door open during WASH together with sig_Wash_Completed=1 -> ERROR, drain_pump=1, motor_on=0; clear_error=1 with the door open -> stays ERROR; door closed plus clear_error -> IDLE.
REQ-032 Bench SHALL cover the watchdog (macro defined, FILL_TIMEOUT=8): hold sig_Full=0 -> ERROR after 8 FILL cycles; sig_Full=1 on cycle 8 -> WASH; with macro undefined, FILL is held for 100 cycles.
REQ-033 Bench SHALL cover saturation and reset: force 256 completed runs -> cycles_done=8'hFF and holds; assert rst_n=0 in SPIN -> next edge state=9'h001, all outputs 0.

Source files
------------

// File: rtl/washing_controller.sv
`default_nettype none
// ============================================================================
//  Module   : washing_controller
//  Purpose  : One-hot phase sequencer for a washing machine. It drives the
//             downstream phase timer and the actuators. Define FILL_WATCHDOG_EN
//             to enable the fill watchdog, which aborts a stalled FILL phase.
//  Revision : 1.0 - initial release
// ============================================================================
module washing_controller #(
    parameter int FILL_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cancel,
    input  logic       door_closed,
    input  logic       clear_error,
    input  logic       sig_Full,
    input  logic       sig_Wash_Completed,
    input  logic       sig_Rinse_Completed,
    input  logic       sig_Spin_Completed,
    input  logic       sig_Drain_Completed,
    input  logic       sig_Delay,
    output logic [8:0] state,
    output logic       water_valve,
    output logic       motor_on,
    output logic       motor_fast,
    output logic       drain_pump,
    output logic       door_lock,
    output logic       done_led,
    output logic       error_flag,
    output logic [7:0] cycles_done
);

    typedef enum logic [8:0] {
        IDLE     = 9'h001,
        READY    = 9'h002,
        FILL     = 9'h004,
        WASH     = 9'h008,
        RINSE    = 9'h010,
        SPIN     = 9'h020,
        DRAIN    = 9'h040,
        COMPLETE = 9'h080,
        ERROR    = 9'h100
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cycles_q, cycles_d;
    logic       fill_expired;

`ifdef FILL_WATCHDOG_EN
    logic [7:0] wd_q, wd_d;

    // The count is the number of FILL cycles already elapsed, so the current
    // cycle is the FILL_TIMEOUT-th one when wd_q + 1 reaches the limit.
    always_comb begin
        wd_d         = 8'd0;
        fill_expired = 1'b0;
        if (state_q == FILL) begin
            wd_d         = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
            fill_expired = ({1'b0, wd_q} + 9'd1) >= 9'(FILL_TIMEOUT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wd_q <= 8'd0;
        else        wd_q <= wd_d;
    end
`else
    assign fill_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        case (state_q)
            IDLE:     if (start && door_closed) state_d = READY;
            READY: begin
                if (!door_closed)   state_d = ERROR;
                else if (cancel)    state_d = IDLE;
                else if (sig_Delay) state_d = FILL;
            end
            FILL: begin
                if (!door_closed)      state_d = ERROR;
                else if (sig_Full)     state_d = WASH;
                else if (fill_expired) state_d = ERROR;
            end
            WASH: begin
                if (!door_closed)            state_d = ERROR;
                else if (sig_Wash_Completed) state_d = RINSE;
            end
            RINSE: begin
                if (!door_closed)             state_d = ERROR;
                else if (sig_Rinse_Completed) state_d = SPIN;
            end
            SPIN: begin
                if (!door_closed)            state_d = ERROR;
                else if (sig_Spin_Completed) state_d = DRAIN;
            end
            DRAIN: begin
                if (!door_closed) state_d = ERROR;
                else if (sig_Drain_Completed) begin
                    state_d = COMPLETE;
                    if (cycles_q != 8'hFF) cycles_d = cycles_q + 8'd1;
                end
            end
            COMPLETE: if (!door_closed) state_d = IDLE;
            ERROR:    if (clear_error && door_closed) state_d = IDLE;
            // Corrupted (non-one-hot) encodings fall back to the safe state.
            default:  state_d = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cycles_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
        end
    end

    assign state       = state_q;
    assign water_valve = (state_q == FILL);
    assign motor_on    = (state_q == WASH) || (state_q == RINSE) || (state_q == SPIN);
    assign motor_fast  = (state_q == SPIN);
    assign drain_pump  = (state_q == DRAIN) || (state_q == ERROR);
    assign door_lock   = (state_q == FILL) || (state_q == WASH) || (state_q == RINSE)
                      || (state_q == SPIN) || (state_q == DRAIN);
    assign done_led    = (state_q == COMPLETE);
    assign error_flag  = (state_q == ERROR);
    assign cycles_done = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_washing_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_washing_controller
//  Purpose  : Directed and random stimulus for washing_controller, checked
//             against a phase-index reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_washing_controller;

`ifdef FILL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, cancel = 1'b0, door_closed = 1'b1, clear_error = 1'b0;
    logic       sig_Full = 1'b0, sig_Wash_Completed = 1'b0, sig_Rinse_Completed = 1'b0;
    logic       sig_Spin_Completed = 1'b0, sig_Drain_Completed = 1'b0, sig_Delay = 1'b0;
    logic [8:0] state;
    logic       water_valve, motor_on, motor_fast, drain_pump, door_lock, done_led, error_flag;
    logic [7:0] cycles_done;

    int total = 0;
    int bad   = 0;

    // Model: phase index 0..8 in the order IDLE..ERROR, completed-run count,
    // and number of FILL cycles already spent.
    int m_idx = 0;
    int m_cnt = 0;
    int m_fc  = 0;

    washing_controller #(.FILL_TIMEOUT(TIMEOUT)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .cancel              (cancel),
        .door_closed         (door_closed),
        .clear_error         (clear_error),
        .sig_Full            (sig_Full),
        .sig_Wash_Completed  (sig_Wash_Completed),
        .sig_Rinse_Completed (sig_Rinse_Completed),
        .sig_Spin_Completed  (sig_Spin_Completed),
        .sig_Drain_Completed (sig_Drain_Completed),
        .sig_Delay           (sig_Delay),
        .state               (state),
        .water_valve         (water_valve),
        .motor_on            (motor_on),
        .motor_fast          (motor_fast),
        .drain_pump          (drain_pump),
        .door_lock           (door_lock),
        .done_led            (done_led),
        .error_flag          (error_flag),
        .cycles_done         (cycles_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("state",       32'(state),       32'(1) << m_idx);
        chk("water_valve", 32'(water_valve), 32'(m_idx == 2));
        chk("motor_on",    32'(motor_on),    32'(m_idx >= 3 && m_idx <= 5));
        chk("motor_fast",  32'(motor_fast),  32'(m_idx == 5));
        chk("drain_pump",  32'(drain_pump),  32'(m_idx == 6 || m_idx == 8));
        chk("door_lock",   32'(door_lock),   32'(m_idx >= 2 && m_idx <= 6));
        chk("done_led",    32'(done_led),    32'(m_idx == 7));
        chk("error_flag",  32'(error_flag),  32'(m_idx == 8));
        chk("cycles_done", 32'(cycles_done), 32'(m_cnt));
    endtask

    // Advance one clock: predict from the inputs currently applied, then compare.
    task automatic step();
        int n_idx = m_idx;
        int n_cnt = m_cnt;
        int n_fc;
        logic [4:0] fl = {sig_Drain_Completed, sig_Spin_Completed, sig_Rinse_Completed,
                          sig_Wash_Completed, sig_Full};
        n_fc = (m_idx == 2) ? m_fc + 1 : 0;
        if (!rst_n) begin
            n_idx = 0; n_cnt = 0; n_fc = 0;
        end else if (m_idx == 0) begin
            if (start && door_closed) n_idx = 1;
        end else if (m_idx == 7) begin
            if (!door_closed) n_idx = 0;
        end else if (m_idx == 8) begin
            if (clear_error && door_closed) n_idx = 0;
        end else if (!door_closed) begin
            n_idx = 8;
        end else if (m_idx == 1) begin
            if (cancel) n_idx = 0;
            else if (sig_Delay) n_idx = 2;
        end else if (fl[m_idx-2]) begin
            n_idx = m_idx + 1;
            if (m_idx == 6 && m_cnt < 255) n_cnt = m_cnt + 1;
        end else if (WD && m_idx == 2 && m_fc + 1 >= TIMEOUT) begin
            n_idx = 8;
        end
        @(posedge clk);
        #1;
        m_idx = n_idx; m_cnt = n_cnt; m_fc = n_fc;
        check_model();
    endtask

    task automatic clear_inputs();
        start = 0; cancel = 0; clear_error = 0; sig_Full = 0; sig_Wash_Completed = 0;
        sig_Rinse_Completed = 0; sig_Spin_Completed = 0; sig_Drain_Completed = 0; sig_Delay = 0;
    endtask

    task automatic do_reset();
        clear_inputs(); rst_n = 0; step(); rst_n = 1;
    endtask

    task automatic full_run();
        door_closed = 1;
        start = 1;               step(); start = 0;
        sig_Delay = 1;           step(); sig_Delay = 0;
        sig_Full = 1;            step(); sig_Full = 0;
        sig_Wash_Completed = 1;  step(); sig_Wash_Completed = 0;
        sig_Rinse_Completed = 1; step(); sig_Rinse_Completed = 0;
        sig_Spin_Completed = 1;  step(); sig_Spin_Completed = 0;
        sig_Drain_Completed = 1; step(); sig_Drain_Completed = 0;
        door_closed = 0;         step(); door_closed = 1;
    endtask

    initial begin
        // Reset state
        rst_n = 0; step(); step(); rst_n = 1;
        chk("rst_state", 32'(state), 32'h001);
        chk("rst_cycles", 32'(cycles_done), 32'h0);

        // Start with the door open is ignored
        door_closed = 0; start = 1; step(); start = 0; door_closed = 1;
        chk("start_door_open", 32'(state), 32'h001);

        // Normal run walks every phase
        start = 1;               step(); start = 0;               chk("run_ready", 32'(state), 32'h002);
        sig_Delay = 1;           step(); sig_Delay = 0;           chk("run_fill",  32'(state), 32'h004);
        sig_Full = 1;            step(); sig_Full = 0;            chk("run_wash",  32'(state), 32'h008);
        sig_Wash_Completed = 1;  step(); sig_Wash_Completed = 0;  chk("run_rinse", 32'(state), 32'h010);
        sig_Rinse_Completed = 1; step(); sig_Rinse_Completed = 0; chk("run_spin",  32'(state), 32'h020);
        sig_Spin_Completed = 1;  step(); sig_Spin_Completed = 0;  chk("run_drain", 32'(state), 32'h040);
        sig_Drain_Completed = 1; step(); sig_Drain_Completed = 0; chk("run_done",  32'(state), 32'h080);
        chk("run_cycles", 32'(cycles_done), 32'h1);
        chk("run_led", 32'(done_led), 32'h1);
        door_closed = 0; step(); door_closed = 1;                chk("run_idle", 32'(state), 32'h001);

        // Cancel beats sig_Delay in READY
        start = 1; step(); start = 0;
        cancel = 1; sig_Delay = 1; step(); cancel = 0; sig_Delay = 0;
        chk("cancel_idle", 32'(state), 32'h001);
        chk("cancel_valve", 32'(water_valve), 32'h0);

        // Door open in WASH beats sig_Wash_Completed
        start = 1; step(); start = 0;
        sig_Delay = 1; step(); sig_Delay = 0;
        sig_Full = 1; step(); sig_Full = 0;
        door_closed = 0; sig_Wash_Completed = 1; step(); sig_Wash_Completed = 0;
        chk("door_err", 32'(state), 32'h100);
        chk("door_pump", 32'(drain_pump), 32'h1);
        chk("door_motor", 32'(motor_on), 32'h0);
        clear_error = 1; step();
        chk("clear_door_open", 32'(state), 32'h100);
        door_closed = 1; step(); clear_error = 0;
        chk("clear_idle", 32'(state), 32'h001);

        // Fill watchdog: sig_Full held low
        start = 1; step(); start = 0;
        sig_Delay = 1; step(); sig_Delay = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (i == TIMEOUT - 1) chk("wd_fill_before", 32'(state), 32'h004);
            if (i == TIMEOUT) chk("wd_at_limit", 32'(state), WD ? 32'h100 : 32'h004);
        end
        chk("wd_end", 32'(state), WD ? 32'h100 : 32'h004);
        do_reset();

        // Fill watchdog: sig_Full arrives in the last allowed cycle
        start = 1; step(); start = 0;
        sig_Delay = 1; step(); sig_Delay = 0;
        for (int i = 1; i < TIMEOUT; i++) step();
        sig_Full = 1; step(); sig_Full = 0;
        chk("wd_full_wins", 32'(state), 32'h008);
        do_reset();

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            rst_n               = ($urandom_range(63) != 0);
            door_closed         = ($urandom_range(15) != 0);
            start               = ($urandom_range(3) == 0);
            cancel              = ($urandom_range(7) == 0);
            clear_error         = ($urandom_range(3) == 0);
            sig_Delay           = ($urandom_range(2) == 0);
            sig_Full            = ($urandom_range(3) == 0);
            sig_Wash_Completed  = ($urandom_range(3) == 0);
            sig_Rinse_Completed = ($urandom_range(3) == 0);
            sig_Spin_Completed  = ($urandom_range(3) == 0);
            sig_Drain_Completed = ($urandom_range(3) == 0);
            step();
        end
        rst_n = 1; door_closed = 1;
        do_reset();

        // Saturation of the run counter
        for (int r = 0; r < 257; r++) full_run();
        chk("sat_ff", 32'(cycles_done), 32'hFF);

        // Reset mid-phase in SPIN
        start = 1; step(); start = 0;
        sig_Delay = 1; step(); sig_Delay = 0;
        sig_Full = 1; step(); sig_Full = 0;
        sig_Wash_Completed = 1; step(); sig_Wash_Completed = 0;
        sig_Rinse_Completed = 1; step(); sig_Rinse_Completed = 0;
        chk("pre_rst_spin", 32'(state), 32'h020);
        rst_n = 0; sig_Spin_Completed = 1; step(); sig_Spin_Completed = 0; rst_n = 1;
        chk("rst_spin_state", 32'(state), 32'h001);
        chk("rst_spin_outs", {25'd0, water_valve, motor_on, motor_fast, drain_pump,
                              door_lock, done_led, error_flag}, 32'h0);
        chk("rst_spin_cycles", 32'(cycles_done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
